param_stack: RTL and testbench

- Parametrised hardware LIFO stack. Combines a stack pointer and a storage array in one block.
- Adds an op-coded command interface (PUSH/POP/REPLACE/DUP/SWAP/CLEAR), full/empty status and sticky error flags.
- Adds a tri-state bus port, used as a push source or as a top-of-stack driver.
- Sits beside the register file on the shared data bus; serves as the CPU call/data stack.

---
 rtl/param_stack_pkg.sv | 32 +++
 rtl/param_stack_if.sv | 40 ++++
 rtl/param_stack_ctrl.sv | 182 ++++++++++++++++++
 rtl/param_stack.sv | 97 +++++++++
 tb/tb_param_stack.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/param_stack_pkg.sv
// -----------------------------------------------------------------------------
// param_stack_pkg
// Shared definitions for the parametrised LIFO stack:
//   - command opcodes carried on i_op
//   - controller FSM state encoding
//   - write-data source select driven by the controller into the datapath
// -----------------------------------------------------------------------------
package param_stack_pkg;

   localparam logic [2:0] OP_NOP     = 3'd0;
   localparam logic [2:0] OP_PUSH    = 3'd1;
   localparam logic [2:0] OP_POP     = 3'd2;
   localparam logic [2:0] OP_REPLACE = 3'd3;
   localparam logic [2:0] OP_DUP     = 3'd4;
   localparam logic [2:0] OP_SWAP    = 3'd5;
   localparam logic [2:0] OP_CLEAR   = 3'd6;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWAP2 = 1'b1
   } state_t;

   // Where the array write port takes its data from.
   typedef enum logic [2:0] {
      WSEL_DATA = 3'd0,   // i_data
      WSEL_BUS  = 3'd1,   // shared bus
      WSEL_TOP  = 3'd2,   // mem[sp-1] (DUP)
      WSEL_NEXT = 3'd3,   // mem[sp-2] (first SWAP cycle)
      WSEL_TMP  = 3'd4    // latched old top (second SWAP cycle)
   } wsel_t;

endpackage

// File: rtl/param_stack_if.sv
// -----------------------------------------------------------------------------
// param_stack_if
// Command / status bundle of the stack.
//   master : issues commands (i_valid, i_op, i_src_bus, i_data, i_bus_oe,
//            i_clear_err) and observes status.
//   slave  : the stack; returns o_ready, o_top, o_count, o_empty, o_full,
//            o_overflow, o_underflow.
// The tri-state data bus is not part of the bundle; it is a plain inout port.
// -----------------------------------------------------------------------------
interface param_stack_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             i_valid;
   logic             o_ready;
   logic [2:0]       i_op;
   logic             i_src_bus;
   logic [WIDTH-1:0] i_data;
   logic             i_bus_oe;
   logic             i_clear_err;
   logic [WIDTH-1:0] o_top;
   logic [CNT_W-1:0] o_count;
   logic             o_empty;
   logic             o_full;
   logic             o_overflow;
   logic             o_underflow;

   modport master (
      output i_valid, i_op, i_src_bus, i_data, i_bus_oe, i_clear_err,
      input  o_ready, o_top, o_count, o_empty, o_full, o_overflow, o_underflow
   );

   modport slave (
      input  i_valid, i_op, i_src_bus, i_data, i_bus_oe, i_clear_err,
      output o_ready, o_top, o_count, o_empty, o_full, o_overflow, o_underflow
   );

endinterface

// File: rtl/param_stack_ctrl.sv
// -----------------------------------------------------------------------------
// param_stack_ctrl
// Control half of the stack: FSM, stack pointer and sticky error flags.
// Ports:
//   i_clock, i_reset_n  clock, asynchronous active-low reset
//   i_valid, i_op       command strobe and opcode
//   i_src_bus           PUSH/REPLACE source select (1 = bus, 0 = i_data)
//   i_clear_err         clears sticky flags (an error in the same cycle wins)
//   o_ready             command can be accepted this cycle (registered)
//   o_sp                stack pointer == occupancy
//   o_we, o_waddr       array write strobe and address for the accepting edge
//   o_wsel              array write data source
//   o_tmp_le            capture the current top into the SWAP holding register
//   o_overflow/underflow sticky error flags
// -----------------------------------------------------------------------------
module param_stack_ctrl
   import param_stack_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH + 1),
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_valid,
   input  logic [2:0]       i_op,
   input  logic             i_src_bus,
   input  logic             i_clear_err,
   output logic             o_ready,
   output logic [CNT_W-1:0] o_sp,
   output logic             o_we,
   output logic [AW-1:0]    o_waddr,
   output wsel_t            o_wsel,
   output logic             o_tmp_le,
   output logic             o_overflow,
   output logic             o_underflow
);

   state_t           state;
   logic [CNT_W-1:0] sp;
   logic [CNT_W-1:0] sp_nxt;
   logic             ready_r;
   logic             ovf_r;
   logic             udf_r;
   logic             accept;
   logic             is_empty;
   logic             is_full;
   logic             has_two;
   logic             ovf_set;
   logic             udf_set;
   logic             clr_all;
   logic             go_swap;
   wsel_t            src_sel;

   assign accept   = i_valid && ready_r;
   assign is_empty = (sp == '0);
   assign is_full  = (sp == CNT_W'(DEPTH));
   assign has_two  = (sp >= CNT_W'(2));
   assign src_sel  = i_src_bus ? WSEL_BUS : WSEL_DATA;

   // Command decode. Array writes must land on the accepting edge, so the
   // write strobe/address/select are decoded combinationally from the
   // current command and the registered state.
   always_comb begin
      sp_nxt   = sp;
      o_we     = 1'b0;
      o_waddr  = AW'(sp);
      o_wsel   = WSEL_DATA;
      o_tmp_le = 1'b0;
      ovf_set  = 1'b0;
      udf_set  = 1'b0;
      clr_all  = 1'b0;
      go_swap  = 1'b0;

      if (state == ST_SWAP2) begin
         // Second half of SWAP: old top goes one below the new top.
         o_we    = 1'b1;
         o_waddr = AW'(sp - CNT_W'(2));
         o_wsel  = WSEL_TMP;
      end else if (accept) begin
         unique case (i_op)
            OP_PUSH: begin
               if (is_full) begin
                  ovf_set = 1'b1;
               end else begin
                  o_we    = 1'b1;
                  o_waddr = AW'(sp);
                  o_wsel  = src_sel;
                  sp_nxt  = sp + CNT_W'(1);
               end
            end
            OP_POP: begin
               if (is_empty) udf_set = 1'b1;
               else          sp_nxt  = sp - CNT_W'(1);
            end
            OP_REPLACE: begin
               if (is_empty) begin
                  udf_set = 1'b1;
               end else begin
                  o_we    = 1'b1;
                  o_waddr = AW'(sp - CNT_W'(1));
                  o_wsel  = src_sel;
               end
            end
            OP_DUP: begin
               if (is_empty) begin
                  udf_set = 1'b1;
               end else if (is_full) begin
                  ovf_set = 1'b1;
               end else begin
                  o_we    = 1'b1;
                  o_waddr = AW'(sp);
                  o_wsel  = WSEL_TOP;
                  sp_nxt  = sp + CNT_W'(1);
               end
            end
            OP_SWAP: begin
               if (!has_two) begin
                  udf_set = 1'b1;
               end else begin
                  o_we     = 1'b1;
                  o_waddr  = AW'(sp - CNT_W'(1));
                  o_wsel   = WSEL_NEXT;
                  o_tmp_le = 1'b1;
                  go_swap  = 1'b1;
               end
            end
            OP_CLEAR: begin
               sp_nxt  = '0;
               clr_all = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state   <= ST_IDLE;
         sp      <= '0;
         ready_r <= 1'b1;
         ovf_r   <= 1'b0;
         udf_r   <= 1'b0;
      end else begin
         sp <= sp_nxt;

         unique case (state)
            ST_IDLE: begin
               if (go_swap) begin
                  state   <= ST_SWAP2;
                  ready_r <= 1'b0;
               end
            end
            ST_SWAP2: begin
               state   <= ST_IDLE;
               ready_r <= 1'b1;
            end
            default: begin
               state   <= ST_IDLE;
               ready_r <= 1'b1;
            end
         endcase

         // CLEAR never raises an error itself, so it simply wipes both flags.
         // Otherwise an error event beats a simultaneous i_clear_err.
         if (clr_all)          ovf_r <= 1'b0;
         else if (ovf_set)     ovf_r <= 1'b1;
         else if (i_clear_err) ovf_r <= 1'b0;

         if (clr_all)          udf_r <= 1'b0;
         else if (udf_set)     udf_r <= 1'b1;
         else if (i_clear_err) udf_r <= 1'b0;
      end
   end

   assign o_ready     = ready_r;
   assign o_sp        = sp;
   assign o_overflow  = ovf_r;
   assign o_underflow = udf_r;

endmodule

// File: rtl/param_stack.sv
// -----------------------------------------------------------------------------
// param_stack
// Parametrised hardware LIFO used as the CPU call/data stack next to the
// register file on the shared data bus.
// Ports:
//   i_clock    system clock (rising edge)
//   i_reset_n  asynchronous active-low reset (array contents are kept)
//   bus        shared tri-state data bus: push source, or driven with the
//              current top when cmd.i_bus_oe is set
//   cmd        param_stack_if.slave: command handshake and status outputs
// Holds the storage array, combinational top-of-stack read and the bus driver;
// sequencing and flags live in param_stack_ctrl.
// -----------------------------------------------------------------------------
module param_stack
   import param_stack_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   inout  wire  [WIDTH-1:0] bus,
   param_stack_if.slave     cmd
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] tmp;
   logic [WIDTH-1:0] top_w;
   logic [WIDTH-1:0] next_w;
   logic [WIDTH-1:0] wdata;
   logic [CNT_W-1:0] sp;
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    next_idx;
   logic [AW-1:0]    waddr;
   logic             we;
   logic             tmp_le;
   wsel_t            wsel;

   param_stack_ctrl #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W),
      .AW    (AW)
   ) u_ctrl (
      .i_clock     (i_clock),
      .i_reset_n   (i_reset_n),
      .i_valid     (cmd.i_valid),
      .i_op        (cmd.i_op),
      .i_src_bus   (cmd.i_src_bus),
      .i_clear_err (cmd.i_clear_err),
      .o_ready     (cmd.o_ready),
      .o_sp        (sp),
      .o_we        (we),
      .o_waddr     (waddr),
      .o_wsel      (wsel),
      .o_tmp_le    (tmp_le),
      .o_overflow  (cmd.o_overflow),
      .o_underflow (cmd.o_underflow)
   );

   // Combinational read of the top two entries. The indices wrap when the
   // stack is shallow, but those reads are masked (top) or never selected
   // (next is only written from on a legal SWAP, i.e. sp >= 2).
   assign top_idx  = AW'(sp - CNT_W'(1));
   assign next_idx = AW'(sp - CNT_W'(2));
   assign top_w    = (sp != '0) ? mem[top_idx] : '0;
   assign next_w   = mem[next_idx];

   // Pushing from the bus while we drive it ourselves simply re-pushes the
   // current top, which is the documented DUP-equivalent behaviour.
   assign bus = cmd.i_bus_oe ? top_w : 'z;

   always_comb begin
      wdata = cmd.i_data;
      unique case (wsel)
         WSEL_DATA: wdata = cmd.i_data;
         WSEL_BUS:  wdata = bus;
         WSEL_TOP:  wdata = top_w;
         WSEL_NEXT: wdata = next_w;
         WSEL_TMP:  wdata = tmp;
         default:   wdata = cmd.i_data;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (we)     mem[waddr] <= wdata;
      if (tmp_le) tmp        <= top_w;
   end

   assign cmd.o_top   = top_w;
   assign cmd.o_count = sp;
   assign cmd.o_empty = (sp == '0);
   assign cmd.o_full  = (sp == CNT_W'(DEPTH));

endmodule

// File: tb/tb_param_stack.sv
// -----------------------------------------------------------------------------
// tb_param_stack
// Directed scenarios followed by randomized commands for a DEPTH=4 stack,
// compared against a queue-based reference model of the LIFO.
// -----------------------------------------------------------------------------
module tb_param_stack;
   import param_stack_pkg::*;

   localparam int W = 16;
   localparam int D = 4;

   logic          clock;
   logic          reset_n;
   wire  [W-1:0]  bus;
   logic          tb_bus_en;
   logic [W-1:0]  tb_bus_val;

   int tests;
   int fails;

   // Reference model state
   logic [W-1:0] q[$];
   logic         m_ovf;
   logic         m_udf;

   assign bus = tb_bus_en ? tb_bus_val : 'z;

   param_stack_if #(.WIDTH(W), .DEPTH(D)) sif ();

   param_stack #(.WIDTH(W), .DEPTH(D)) dut (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .bus       (bus),
      .cmd       (sif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] m_top();
      return (q.size() > 0) ? q[q.size()-1] : '0;
   endfunction

   // Apply one command (or NOP for a cycle with no accepted command) to the
   // model. Legal SWAPs are handled by the caller.
   task automatic model_apply(input logic [2:0] op, input logic [W-1:0] srcv, input logic clr);
      logic eo;
      logic eu;
      eo = 1'b0;
      eu = 1'b0;
      case (op)
         OP_PUSH:    if (q.size() == D) eo = 1'b1; else q.push_back(srcv);
         OP_POP:     if (q.size() == 0) eu = 1'b1; else void'(q.pop_back());
         OP_REPLACE: if (q.size() == 0) eu = 1'b1; else q[q.size()-1] = srcv;
         OP_DUP: begin
            if (q.size() == 0)      eu = 1'b1;
            else if (q.size() == D) eo = 1'b1;
            else                    q.push_back(q[q.size()-1]);
         end
         OP_SWAP:    if (q.size() < 2) eu = 1'b1;
         OP_CLEAR: begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
         end
         default: ;
      endcase
      if (op != OP_CLEAR) begin
         m_ovf = eo ? 1'b1 : (clr ? 1'b0 : m_ovf);
         m_udf = eu ? 1'b1 : (clr ? 1'b0 : m_udf);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_count"}, 32'(sif.o_count), 32'(q.size()));
      chk({tag, "_top"},   32'(sif.o_top),   32'(m_top()));
      chk({tag, "_empty"}, 32'(sif.o_empty), 32'(q.size() == 0));
      chk({tag, "_full"},  32'(sif.o_full),  32'(q.size() == D));
      chk({tag, "_ovf"},   32'(sif.o_overflow),  32'(m_ovf));
      chk({tag, "_udf"},   32'(sif.o_underflow), 32'(m_udf));
      chk({tag, "_ready"}, 32'(sif.o_ready), 32'd1);
      if (sif.i_bus_oe) chk({tag, "_bus"}, 32'(bus), 32'(m_top()));
   endtask

   task automatic do_op(input string tag, input logic v, input logic [2:0] op,
                        input logic src, input logic [W-1:0] d, input logic oe,
                        input logic [W-1:0] bv, input logic clr);
      logic [W-1:0] srcv;
      logic [W-1:0] t;
      sif.i_valid     = v;
      sif.i_op        = op;
      sif.i_src_bus   = src;
      sif.i_data      = d;
      sif.i_bus_oe    = oe;
      sif.i_clear_err = clr;
      tb_bus_en       = !oe;
      tb_bus_val      = bv;
      srcv = src ? (oe ? m_top() : bv) : d;
      @(posedge clock); #1;
      if (v && op == OP_SWAP && q.size() >= 2) begin
         chk({tag, "_swapbusy_ready"}, 32'(sif.o_ready), 32'd0);
         chk({tag, "_swapbusy_count"}, 32'(sif.o_count), 32'(q.size()));
         chk({tag, "_swapbusy_top"},   32'(sif.o_top),   32'(q[q.size()-2]));
         model_apply(OP_NOP, '0, clr);
         // A command presented while busy must be ignored.
         sif.i_op        = OP_PUSH;
         sif.i_src_bus   = 1'b0;
         sif.i_data      = 16'hDEAD;
         sif.i_clear_err = 1'b0;
         @(posedge clock); #1;
         t = q[q.size()-1];
         q[q.size()-1] = q[q.size()-2];
         q[q.size()-2] = t;
      end else begin
         model_apply(v ? op : OP_NOP, srcv, clr);
      end
      sif.i_valid     = 1'b0;
      sif.i_clear_err = 1'b0;
      check_all(tag);
   endtask

   initial begin
      tests       = 0;
      fails       = 0;
      m_ovf       = 1'b0;
      m_udf       = 1'b0;
      reset_n     = 1'b0;
      tb_bus_en   = 1'b0;
      tb_bus_val  = '0;
      sif.i_valid     = 1'b0;
      sif.i_op        = OP_NOP;
      sif.i_src_bus   = 1'b0;
      sif.i_data      = '0;
      sif.i_bus_oe    = 1'b0;
      sif.i_clear_err = 1'b0;

      // Reset state
      #12;
      check_all("reset");
      @(negedge clock);
      reset_n = 1'b1;

      // 1: basic push/pop
      do_op("t1_push1", 1, OP_PUSH, 0, 16'h1111, 0, 16'h0, 0);
      do_op("t1_push2", 1, OP_PUSH, 0, 16'h2222, 0, 16'h0, 0);
      do_op("t1_push3", 1, OP_PUSH, 0, 16'h3333, 0, 16'h0, 0);
      chk("t1_top3333", 32'(sif.o_top), 32'h3333);
      chk("t1_count3",  32'(sif.o_count), 32'd3);
      do_op("t1_pop", 1, OP_POP, 0, 16'h0, 0, 16'h0, 0);
      chk("t1_top2222", 32'(sif.o_top), 32'h2222);

      // 2: fill to DEPTH, then overflow; clear_err leaves full
      do_op("t2_push3", 1, OP_PUSH, 0, 16'h3333, 0, 16'h0, 0);
      chk("t2_notfull3", 32'(sif.o_full), 32'd0);
      do_op("t2_push4", 1, OP_PUSH, 0, 16'h4444, 0, 16'h0, 0);
      chk("t2_full4", 32'(sif.o_full), 32'd1);
      do_op("t2_push5", 1, OP_PUSH, 0, 16'h5555, 0, 16'h0, 0);
      chk("t2_ovf", 32'(sif.o_overflow), 32'd1);
      chk("t2_top_kept", 32'(sif.o_top), 32'h4444);
      do_op("t2_dupfull", 1, OP_DUP, 0, 16'h0, 0, 16'h0, 0);
      do_op("t2_clrerr", 0, OP_NOP, 0, 16'h0, 0, 16'h0, 1);
      chk("t2_ovf_cleared", 32'(sif.o_overflow), 32'd0);
      chk("t2_still_full", 32'(sif.o_full), 32'd1);
      // error event and clear_err together: set wins
      do_op("t2_setwins", 1, OP_PUSH, 0, 16'h6666, 0, 16'h0, 1);
      chk("t2_setwins_ovf", 32'(sif.o_overflow), 32'd1);

      // 3: underflow cases on empty / single-entry stack
      do_op("t3_clear", 1, OP_CLEAR, 0, 16'h0, 0, 16'h0, 0);
      do_op("t3_pop", 1, OP_POP, 0, 16'h0, 0, 16'h0, 0);
      chk("t3_udf_pop", 32'(sif.o_underflow), 32'd1);
      do_op("t3_repl", 1, OP_REPLACE, 0, 16'h1234, 0, 16'h0, 0);
      do_op("t3_dup", 1, OP_DUP, 0, 16'h0, 0, 16'h0, 0);
      do_op("t3_push", 1, OP_PUSH, 0, 16'h7777, 0, 16'h0, 0);
      do_op("t3_clrerr", 0, OP_NOP, 0, 16'h0, 0, 16'h0, 1);
      do_op("t3_swap1", 1, OP_SWAP, 0, 16'h0, 0, 16'h0, 0);
      chk("t3_udf_swap", 32'(sif.o_underflow), 32'd1);
      chk("t3_count1", 32'(sif.o_count), 32'd1);
      do_op("t3_clear2", 1, OP_CLEAR, 0, 16'h0, 0, 16'h0, 0);
      chk("t3_udf_clr", 32'(sif.o_underflow), 32'd0);

      // 4: two-cycle SWAP
      do_op("t4_pushA", 1, OP_PUSH, 0, 16'hAAAA, 0, 16'h0, 0);
      do_op("t4_pushB", 1, OP_PUSH, 0, 16'hBBBB, 0, 16'h0, 0);
      do_op("t4_swap", 1, OP_SWAP, 0, 16'h0, 0, 16'h0, 0);
      chk("t4_topA", 32'(sif.o_top), 32'hAAAA);
      do_op("t4_pop", 1, OP_POP, 0, 16'h0, 0, 16'h0, 0);
      chk("t4_topB", 32'(sif.o_top), 32'hBBBB);

      // 5: bus as push source and as top driver
      do_op("t5_clear", 1, OP_CLEAR, 0, 16'h0, 0, 16'h0, 0);
      do_op("t5_pushbus", 1, OP_PUSH, 1, 16'h0, 0, 16'h5A5A, 0);
      chk("t5_top5A5A", 32'(sif.o_top), 32'h5A5A);
      do_op("t5_oe", 0, OP_NOP, 0, 16'h0, 1, 16'h0, 0);
      chk("t5_bus5A5A", 32'(bus), 32'h5A5A);
      do_op("t5_dup", 1, OP_DUP, 0, 16'h0, 1, 16'h0, 0);
      chk("t5_count2", 32'(sif.o_count), 32'd2);
      do_op("t5_pushself", 1, OP_PUSH, 1, 16'h0, 1, 16'h0, 0);
      do_op("t5_pop", 1, OP_POP, 0, 16'h0, 1, 16'h0, 0);
      do_op("t5_pop2", 1, OP_POP, 0, 16'h0, 1, 16'h0, 0);
      chk("t5_next5A5A", 32'(sif.o_top), 32'h5A5A);

      // 6: reset during the second SWAP cycle
      do_op("t6_push1", 1, OP_PUSH, 0, 16'hC001, 0, 16'h0, 0);
      do_op("t6_push2", 1, OP_PUSH, 0, 16'hC002, 0, 16'h0, 0);
      sif.i_valid = 1'b1;
      sif.i_op    = OP_SWAP;
      @(posedge clock); #1;
      sif.i_valid = 1'b0;
      chk("t6_inswap_ready", 32'(sif.o_ready), 32'd0);
      reset_n = 1'b0;
      #1;
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      chk("t6_rst_count", 32'(sif.o_count), 32'd0);
      chk("t6_rst_ready", 32'(sif.o_ready), 32'd1);
      chk("t6_rst_empty", 32'(sif.o_empty), 32'd1);
      @(negedge clock);
      reset_n = 1'b1;
      do_op("t6_push", 1, OP_PUSH, 0, 16'h0001, 0, 16'h0, 0);
      chk("t6_top1", 32'(sif.o_top), 32'h0001);

      // Randomized commands against the model
      for (int i = 0; i < 300; i++) begin
         logic          rv;
         logic [2:0]    rop;
         logic          rsrc;
         logic          roe;
         logic          rclr;
         rv   = ($urandom_range(0, 9) != 0);
         rop  = 3'($urandom_range(0, 7));
         rsrc = 1'($urandom);
         roe  = 1'($urandom);
         rclr = ($urandom_range(0, 7) == 0);
         do_op("rnd", rv, rop, rsrc, 16'($urandom), roe, 16'($urandom), rclr);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
